// File: rtl/lsm_sequencer.sv
// Load/store-multiple sequencer: walks a register bitmap lowest-bit-first, emitting one
// (register index, memory address) transfer per accepted cycle, and freezes fetch/decode meanwhile.
//
//   state  | meaning
//   IDLE   | waiting for an LM/SM at decode
//   RUN    | presenting transfers from the pending list
//   FIN    | one-cycle done pulse, then back to IDLE
module lsm_sequencer #(
   parameter  int N_REGS    = 8,
   parameter  int ADDR_W    = 16,
   parameter  int ADDR_STEP = 1,
   localparam int IDX_W     = $clog2(N_REGS)
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              start,
   input  logic              mode,
   input  logic [N_REGS-1:0] reg_list,
   input  logic [ADDR_W-1:0] base_addr,
   input  logic              adv,
   input  logic              flush,
   output logic              busy,
   output logic              stall_req,
   output logic              valid,
   output logic [IDX_W-1:0]  r_idx,
   output logic [ADDR_W-1:0] mem_addr,
   output logic              is_store,
   output logic              last,
   output logic              done
);

   typedef enum logic [1:0] {S_IDLE, S_RUN, S_FIN} state_t;

   localparam logic [N_REGS-1:0] ONE = {{(N_REGS-1){1'b0}}, 1'b1};

   state_t            state, state_nxt;
   logic [N_REGS-1:0] pending;
   logic [N_REGS-1:0] low_bit;
   logic              one_left;

   // isolate the lowest set bit via two's complement
   assign low_bit  = pending & (~pending + ONE);
   assign one_left = (pending != '0) && ((pending & (pending - ONE)) == '0);

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) state <= S_IDLE;
      else          state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      if (flush) begin
         state_nxt = S_IDLE;
      end else begin
         case (state)
            S_IDLE:  if (start) state_nxt = (reg_list != '0) ? S_RUN : S_FIN;
            S_RUN:   if (adv && one_left) state_nxt = S_FIN;
            S_FIN:   state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         pending  <= '0;
         mem_addr <= '0;
         is_store <= 1'b0;
      end else if (flush) begin
         pending <= '0;
      end else if (state == S_IDLE && start) begin
         pending  <= reg_list;
         mem_addr <= base_addr;
         is_store <= mode;
      end else if (state == S_RUN && adv) begin
         pending  <= pending & ~low_bit;
         mem_addr <= mem_addr + ADDR_W'(ADDR_STEP);
      end
   end

   always_comb begin
      r_idx = '0;
      for (int i = N_REGS - 1; i >= 0; i--) begin
         if (pending[i]) r_idx = IDX_W'(i);
      end
   end

   always_comb begin
      busy      = (state == S_RUN);
      valid     = (state == S_RUN);
      last      = (state == S_RUN) && one_left;
      done      = (state == S_FIN) && !flush;
      stall_req = (state == S_RUN) || (state == S_FIN) ||
                  ((state == S_IDLE) && start && !flush);
   end

endmodule

// File: tb/tb_lsm_sequencer.sv
// Scoreboard bench for lsm_sequencer: expected transfers are queued at launch and
// compared by a monitor whenever the sequencer presents a live transfer.
module tb_lsm_sequencer;

   localparam int N_REGS = 8;
   localparam int ADDR_W = 16;
   localparam int IDX_W  = 3;

   typedef struct packed {
      logic [IDX_W-1:0]  idx;
      logic [ADDR_W-1:0] addr;
      logic              lst;
      logic              st;
   } xfer_t;

   logic              clk = 1'b0;
   logic              reset_n = 1'b0;
   logic              start = 1'b0;
   logic              mode = 1'b0;
   logic [N_REGS-1:0] reg_list = '0;
   logic [ADDR_W-1:0] base_addr = '0;
   logic              adv = 1'b0;
   logic              flush = 1'b0;
   logic              busy, stall_req, valid, is_store, last, done;
   logic [IDX_W-1:0]  r_idx;
   logic [ADDR_W-1:0] mem_addr;

   int    tests_run = 0;
   int    fails = 0;
   xfer_t exp_q[$];
   xfer_t obs;

   lsm_sequencer #(.N_REGS(N_REGS), .ADDR_W(ADDR_W), .ADDR_STEP(1)) dut (
      .clk(clk), .reset_n(reset_n), .start(start), .mode(mode), .reg_list(reg_list),
      .base_addr(base_addr), .adv(adv), .flush(flush), .busy(busy), .stall_req(stall_req),
      .valid(valid), .r_idx(r_idx), .mem_addr(mem_addr), .is_store(is_store),
      .last(last), .done(done)
   );

   always #5 clk = ~clk;

   assign obs = '{idx: r_idx, addr: mem_addr, lst: last, st: is_store};

   always @(negedge clk) begin
      if (reset_n && valid) begin
         tests_run++;
         if (exp_q.size() == 0) begin
            fails++;
            $display("FAIL xfer_unexpected: got idx=%0d addr=%h, required no transfer", r_idx, mem_addr);
         end else begin
            if (obs !== exp_q[0]) begin
               fails++;
               $display("FAIL xfer: got idx=%0d addr=%h last=%b st=%b, required idx=%0d addr=%h last=%b st=%b",
                        obs.idx, obs.addr, obs.lst, obs.st,
                        exp_q[0].idx, exp_q[0].addr, exp_q[0].lst, exp_q[0].st);
            end
            if (adv && !flush) void'(exp_q.pop_front());
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic push_model(input logic [N_REGS-1:0] list, input logic [ADDR_W-1:0] base, input logic m);
      int cnt = 0;
      int k = 0;
      logic [ADDR_W-1:0] a = base;
      for (int i = 0; i < N_REGS; i++) if (list[i]) cnt++;
      for (int i = 0; i < N_REGS; i++) begin
         if (list[i]) begin
            k++;
            exp_q.push_back('{idx: IDX_W'(i), addr: a, lst: (k == cnt), st: m});
            a = a + 16'd1;
         end
      end
   endtask

   task automatic launch(input logic [N_REGS-1:0] list, input logic [ADDR_W-1:0] base,
                         input logic m, output logic stall0);
      reg_list  = list;
      base_addr = base;
      mode      = m;
      start     = 1'b1;
      push_model(list, base, m);
      @(negedge clk);
      stall0 = stall_req;
      tick();
      start = 1'b0;
   endtask

   task automatic observe(input int n, input int hold_idx, input int hold_n,
                          output int done_at, output int done_cnt,
                          output int valid_cnt, output int stall_cnt);
      int held = 0;
      done_at = -1; done_cnt = 0; valid_cnt = 0; stall_cnt = 0;
      for (int c = 1; c <= n; c++) begin
         if (valid && int'(r_idx) == hold_idx && held < hold_n) begin
            adv = 1'b0;
            held++;
         end else begin
            adv = 1'b1;
         end
         @(negedge clk);
         if (done) begin
            done_cnt++;
            if (done_at < 0) done_at = c;
         end
         if (valid) valid_cnt++;
         if (stall_req) stall_cnt++;
         tick();
      end
      adv = 1'b0;
   endtask

   task automatic test_reset();
      reset_n = 1'b0;
      repeat (2) @(negedge clk);
      tests_run++;
      if ({busy, valid, last, done, stall_req, is_store, r_idx, mem_addr} !== '0) begin
         fails++;
         $display("FAIL reset_state: got busy=%b valid=%b last=%b done=%b stall=%b st=%b idx=%0d addr=%h, required all 0",
                  busy, valid, last, done, stall_req, is_store, r_idx, mem_addr);
      end
      tick();
      reset_n = 1'b1;
      tick();
   endtask

   task automatic test_lm_basic();
      logic s0;
      int da, dc, vc, sc;
      launch(8'hA5, 16'h0010, 1'b0, s0);
      observe(10, -1, 0, da, dc, vc, sc);
      tests_run++;
      if (s0 !== 1'b1) begin fails++; $display("FAIL lm_start_stall: got %b, required 1", s0); end
      tests_run++;
      if (da != 5 || dc != 1) begin fails++; $display("FAIL lm_done: got cycle %0d count %0d, required cycle 5 count 1", da, dc); end
      tests_run++;
      if (vc != 4 || sc != 5) begin fails++; $display("FAIL lm_counts: got valid %0d stall %0d, required 4 and 5", vc, sc); end
      tests_run++;
      if (exp_q.size() != 0) begin fails++; $display("FAIL lm_drain: got %0d left, required 0", exp_q.size()); end
   endtask

   task automatic test_sm_backpressure();
      logic s0;
      int da, dc, vc, sc;
      launch(8'hA5, 16'h0010, 1'b1, s0);
      observe(14, 2, 3, da, dc, vc, sc);
      tests_run++;
      if (vc != 7 || da != 8 || dc != 1) begin
         fails++;
         $display("FAIL sm_hold: got valid %0d done cycle %0d count %0d, required 7, 8, 1", vc, da, dc);
      end
      tests_run++;
      if (exp_q.size() != 0) begin fails++; $display("FAIL sm_drain: got %0d left, required 0", exp_q.size()); end
   endtask

   task automatic test_empty_list();
      logic s0;
      int da, dc, vc, sc;
      launch(8'h00, 16'h0033, 1'b0, s0);
      observe(5, -1, 0, da, dc, vc, sc);
      tests_run++;
      if (vc != 0 || da != 1 || dc != 1) begin
         fails++;
         $display("FAIL empty_done: got valid %0d done cycle %0d count %0d, required 0, 1, 1", vc, da, dc);
      end
      tests_run++;
      if (s0 !== 1'b1 || sc != 1) begin
         fails++;
         $display("FAIL empty_stall: got start %b later %0d, required 1 and 1", s0, sc);
      end
   endtask

   task automatic test_addr_wrap();
      logic s0;
      int da, dc, vc, sc;
      launch(8'h0F, 16'hFFFE, 1'b0, s0);
      observe(8, -1, 0, da, dc, vc, sc);
      tests_run++;
      if (vc != 4 || da != 5 || exp_q.size() != 0) begin
         fails++;
         $display("FAIL wrap: got valid %0d done cycle %0d left %0d, required 4, 5, 0", vc, da, exp_q.size());
      end
   endtask

   task automatic test_flush();
      logic s0;
      int da, dc, vc, sc;
      launch(8'hFF, 16'h0030, 1'b0, s0);
      adv = 1'b1;
      for (int c = 1; c <= 3; c++) begin
         if (c == 3) flush = 1'b1;
         @(negedge clk);
         tick();
      end
      flush = 1'b0;
      adv = 1'b0;
      exp_q.delete();
      @(negedge clk);
      tests_run++;
      if ({valid, busy, stall_req, done} !== 4'b0) begin
         fails++;
         $display("FAIL flush_clear: got valid=%b busy=%b stall=%b done=%b, required 0000", valid, busy, stall_req, done);
      end
      tick();
      observe(4, -1, 0, da, dc, vc, sc);
      tests_run++;
      if (dc != 0 || vc != 0) begin fails++; $display("FAIL flush_no_done: got done %0d valid %0d, required 0 0", dc, vc); end
      launch(8'h03, 16'h0040, 1'b1, s0);
      observe(6, -1, 0, da, dc, vc, sc);
      tests_run++;
      if (da != 3 || vc != 2 || exp_q.size() != 0) begin
         fails++;
         $display("FAIL flush_restart: got done cycle %0d valid %0d left %0d, required 3, 2, 0", da, vc, exp_q.size());
      end
   endtask

   task automatic test_reset_mid_run();
      logic s0;
      int da, dc, vc, sc;
      launch(8'h3C, 16'h0020, 1'b1, s0);
      adv = 1'b1;
      reg_list = 8'hFF; base_addr = 16'h0099; mode = 1'b0; start = 1'b1;
      @(negedge clk);
      tick();
      start = 1'b0;
      @(negedge clk);
      tick();
      reset_n = 1'b0;
      #1;
      tests_run++;
      if ({busy, valid, last, done, stall_req, is_store, r_idx, mem_addr} !== '0) begin
         fails++;
         $display("FAIL async_reset: got busy=%b valid=%b last=%b done=%b stall=%b st=%b idx=%0d addr=%h, required all 0",
                  busy, valid, last, done, stall_req, is_store, r_idx, mem_addr);
      end
      exp_q.delete();
      adv = 1'b0;
      tick();
      reset_n = 1'b1;
      observe(4, -1, 0, da, dc, vc, sc);
      tests_run++;
      if (dc != 0 || vc != 0) begin fails++; $display("FAIL reset_no_done: got done %0d valid %0d, required 0 0", dc, vc); end
      launch(8'h01, 16'h0005, 1'b0, s0);
      observe(4, -1, 0, da, dc, vc, sc);
      tests_run++;
      if (da != 2 || vc != 1 || exp_q.size() != 0) begin
         fails++;
         $display("FAIL reset_recover: got done cycle %0d valid %0d left %0d, required 2, 1, 0", da, vc, exp_q.size());
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   initial begin
      test_reset();
      test_lm_basic();
      test_sm_backpressure();
      test_empty_list();
      test_addr_wrap();
      test_flush();
      test_reset_mid_run();
      $display("[TB] %0d tests run, %0d failed", tests_run, fails);
      $finish;
   end

endmodule
